// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Parametrised VGA sync/timing generator. Free-running horizontal and vertical
// counters are decoded into sync pulses, display enables, pixel coordinates
// and line/frame strobes. The sync/enable group can be pushed through a
// programmable delay line so it lines up with a downstream pixel pipeline.
// Coordinates and strobes are never delayed.
//
// Ports
//   clk_px       in   1   pixel clock, all logic on the rising edge
//   rst_n        in   1   synchronous reset, active low
//   en           in   1   count enable; low freezes timing and every output
//   hs           out  1   horizontal sync, level H_POL when asserted
//   vs           out  1   vertical sync, level V_POL when asserted
//   hen          out  1   horizontal display enable
//   ven          out  1   vertical display enable
//   de           out  1   hen & ven
//   x            out  CW  horizontal position, 0..H_TOTAL-1
//   y            out  CW  vertical position, 0..V_TOTAL-1
//   line_start   out  1   high for the cycle where x == 0
//   frame_start  out  1   high for the cycle where x == 0 and y == 0
// -----------------------------------------------------------------------------
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter bit          H_POL    = 1'b1,
  parameter bit          V_POL    = 1'b1,
  parameter int unsigned CW       = 11,
  parameter int unsigned PIPE_DLY = 0
) (
  input  logic          clk_px,
  input  logic          rst_n,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          hen,
  output logic          ven,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Parameter sanity: refuse to build a generator that cannot count a line.
  if ((64'(H_TOTAL) > (64'd1 << CW)) || (64'(V_TOTAL) > (64'd1 << CW))) begin : g_err_width
    $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in CW bits");
  end
  if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
      V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_err_zero
    $error("vga_timing_gen: timing periods must be non-zero");
  end
  if (PIPE_DLY > 15) begin : g_err_dly
    $error("vga_timing_gen: PIPE_DLY must be 0..15");
  end

  // Decode points as CW-bit constants so every compare is unsigned CW-bit.
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS_BEG   = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] VS_BEG   = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);

  // The group of signals that travels through the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic hen;
    logic ven;
    logic de;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: ~H_POL, vs: ~V_POL, hen: 1'b0, ven: 1'b0, de: 1'b0};

  logic [CW-1:0] hcnt, vcnt;
  logic [CW-1:0] hcnt_nxt, vcnt_nxt;
  sync_t         s1_d, s1, dly_out;

  // Counter next-state and stage-1 decode.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    hcnt_nxt = hcnt + CW'(1);
    vcnt_nxt = vcnt;
    if (hcnt == H_LAST) begin
      hcnt_nxt = '0;
      vcnt_nxt = (vcnt == V_LAST) ? '0 : vcnt + CW'(1);
    end

    // vs is decoded from vcnt only, so it can change only where vcnt does:
    // on the line wrap.
    s1_d     = SYNC_IDLE;
    s1_d.hen = (hcnt < H_ACT);
    s1_d.ven = (vcnt < V_ACT);
    s1_d.de  = s1_d.hen & s1_d.ven;
    s1_d.hs  = ((hcnt >= HS_BEG) && (hcnt < HS_END)) ? H_POL : ~H_POL;
    s1_d.vs  = ((vcnt >= VS_BEG) && (vcnt < VS_END)) ? V_POL : ~V_POL;
  end

  // Counters and stage-1 output registers.
  // NOTE: sequential state is written with non-blocking assignments so all
  // registers sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk_px) begin
    if (!rst_n) begin
      hcnt        <= '0;
      vcnt        <= '0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      s1          <= SYNC_IDLE;
    end else if (en) begin
      hcnt        <= hcnt_nxt;
      vcnt        <= vcnt_nxt;
      x           <= hcnt;
      y           <= vcnt;
      line_start  <= (hcnt == '0);
      frame_start <= (hcnt == '0) && (vcnt == '0);
      s1          <= s1_d;
    end
  end

  // Optional delay line on the sync/enable group.
  if (PIPE_DLY == 0) begin : g_nodly
    assign dly_out = s1;
  end else begin : g_dly
    sync_t stage [PIPE_DLY];

    // NOTE: the delay stages are reset explicitly; otherwise stale or X
    // sync values would leave the block for PIPE_DLY cycles after reset.
    always_ff @(posedge clk_px) begin
      if (!rst_n) begin
        for (int i = 0; i < int'(PIPE_DLY); i++) stage[i] <= SYNC_IDLE;
      end else if (en) begin
        stage[0] <= s1;
        for (int i = 1; i < int'(PIPE_DLY); i++) stage[i] <= stage[i-1];
      end
    end

    assign dly_out = stage[PIPE_DLY-1];
  end

  assign hs  = dly_out.hs;
  assign vs  = dly_out.vs;
  assign hen = dly_out.hen;
  assign ven = dly_out.ven;
  assign de  = dly_out.de;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen using a reduced raster so whole frames fit
// in a short run:
//   horizontal 8 active + 2 FP + 3 sync + 3 BP = 16 (sync at x 10..12)
//   vertical   4 active + 1 FP + 2 sync + 1 BP = 8  (sync at y 5..6)
//   CW = 4, so H_TOTAL equals 2^CW exactly.
// Instance a: PIPE_DLY=0, positive syncs.  Instance b: PIPE_DLY=3, negative syncs.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;

  logic          a_hs, a_vs, a_hen, a_ven, a_de, a_line_start, a_frame_start;
  logic [CW-1:0] a_x, a_y;
  logic          b_hs, b_vs, b_hen, b_ven, b_de, b_line_start, b_frame_start;
  logic [CW-1:0] b_x, b_y;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(CW), .PIPE_DLY(0)
  ) dut_a (
    .clk_px(clk), .rst_n(rst_n), .en(en),
    .hs(a_hs), .vs(a_vs), .hen(a_hen), .ven(a_ven), .de(a_de),
    .x(a_x), .y(a_y), .line_start(a_line_start), .frame_start(a_frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_POL(1'b0), .V_POL(1'b0), .CW(CW), .PIPE_DLY(3)
  ) dut_b (
    .clk_px(clk), .rst_n(rst_n), .en(en),
    .hs(b_hs), .vs(b_vs), .hen(b_hen), .ven(b_ven), .de(b_de),
    .x(b_x), .y(b_y), .line_start(b_line_start), .frame_start(b_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle on the following falling edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  // Run until instance a shows (tx, ty); bounded.
  task automatic seek(input int tx, input int ty);
    int k = 0;
    while (!(int'(a_x) == tx && int'(a_y) == ty) && k < 300) begin
      step(1);
      k++;
    end
    check($sformatf("seek_%0d_%0d", tx, ty), (int'(a_x) == tx && int'(a_y) == ty), 1);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int de_n, hs_n, vs_n, ven_n, ls_n, fs_n, fs_idx, b_de_n, b_vs_lo, vs_tr, vs_bad, cyc, k;
    logic vs_prev;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    en    = 1'b1;
    step(3);
    check("rst_a_x",  a_x, 0);
    check("rst_a_y",  a_y, 0);
    check("rst_a_hs", a_hs, 0);
    check("rst_a_vs", a_vs, 0);
    check("rst_a_hen", a_hen, 0);
    check("rst_a_ven", a_ven, 0);
    check("rst_a_de", a_de, 0);
    check("rst_a_ls", a_line_start, 0);
    check("rst_a_fs", a_frame_start, 0);
    check("rst_b_hs", b_hs, 1);
    check("rst_b_vs", b_vs, 1);
    check("rst_b_de", b_de, 0);

    // ---------------- first cycle after release ----------------
    rst_n = 1'b1;
    step(1);
    check("rel_fs",  a_frame_start, 1);
    check("rel_ls",  a_line_start, 1);
    check("rel_x",   a_x, 0);
    check("rel_y",   a_y, 0);
    check("rel_de",  a_de, 1);
    check("rel_b_de", b_de, 0);

    // ---------------- first line, cycle by cycle ----------------
    // a: hen for x 0..7, hs for x 10..12.
    // b: 3-cycle delay, flushed idle first -> hen at 3..10, hs low at 13..15.
    for (int i = 0; i < 16; i++) begin
      check($sformatf("l0_x_%0d", i),     a_x, i);
      check($sformatf("l0_ls_%0d", i),    a_line_start, (i == 0));
      check($sformatf("l0_hen_%0d", i),   a_hen, (i < 8));
      check($sformatf("l0_hs_%0d", i),    a_hs, (i >= 10 && i < 13));
      check($sformatf("l0_b_hen_%0d", i), b_hen, (i >= 3 && i <= 10));
      check($sformatf("l0_b_hs_%0d", i),  b_hs, !(i >= 13));
      step(1);
    end
    check("l1_x", a_x, 0);
    check("l1_y", a_y, 1);

    // ---------------- one full frame of statistics ----------------
    // Window starts at (0,1); frame_start seen at index 7*16 = 112.
    de_n = 0; hs_n = 0; vs_n = 0; ven_n = 0; ls_n = 0; fs_n = 0; fs_idx = -1;
    b_de_n = 0; b_vs_lo = 0; vs_tr = 0; vs_bad = 0;
    vs_prev = a_vs;
    for (int i = 0; i < 128; i++) begin
      if (a_de) de_n++;
      if (a_hs) hs_n++;
      if (a_vs) vs_n++;
      if (a_ven) ven_n++;
      if (a_line_start) ls_n++;
      if (a_frame_start) begin fs_n++; fs_idx = i; end
      if (b_de) b_de_n++;
      if (!b_vs) b_vs_lo++;
      if (a_vs !== vs_prev) begin
        vs_tr++;
        if (a_x != '0) vs_bad++;
      end
      vs_prev = a_vs;
      step(1);
    end
    check("frm_de",     de_n, 32);
    check("frm_hs",     hs_n, 24);
    check("frm_vs",     vs_n, 32);
    check("frm_ven",    ven_n, 64);
    check("frm_ls",     ls_n, 8);
    check("frm_fs",     fs_n, 1);
    check("frm_fs_idx", fs_idx, 112);
    check("frm_b_de",   b_de_n, 32);
    check("frm_b_vs",   b_vs_lo, 32);
    check("frm_vs_tr",  vs_tr, 2);
    check("frm_vs_mid", vs_bad, 0);

    // ---------------- enable low for 10 cycles mid-line ----------------
    check("en_y", a_y, 1);
    cyc = 0;
    step(5);
    cyc += 5;
    check("en_pre_x", a_x, 5);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      cyc++;
      check($sformatf("frz_x_%0d", i),     a_x, 5);
      check($sformatf("frz_ls_%0d", i),    a_line_start, 0);
      check($sformatf("frz_hs_%0d", i),    a_hs, 0);
      check($sformatf("frz_b_hen_%0d", i), b_hen, 1);
    end
    en = 1'b1;
    step(1);
    cyc++;
    check("en_resume_x", a_x, 6);
    k = 0;
    while (!a_line_start && k < 40) begin
      step(1);
      cyc++;
      k++;
    end
    check("en_line_period", cyc, 26);
    check("en_next_y", a_y, 2);

    // ---------------- enable low while a strobe is high ----------------
    en = 1'b0;
    step(3);
    check("frz_strobe_ls", a_line_start, 1);
    check("frz_strobe_x",  a_x, 0);
    en = 1'b1;
    step(1);
    check("unfrz_ls", a_line_start, 0);
    check("unfrz_x",  a_x, 1);

    // ---------------- reset mid-frame ----------------
    seek(11, 3);
    check("pre_rst_hs",  a_hs, 1);
    check("pre_rst_ven", a_ven, 1);
    rst_n = 1'b0;
    step(1);
    check("mrst_a_hs", a_hs, 0);
    check("mrst_a_vs", a_vs, 0);
    check("mrst_a_de", a_de, 0);
    check("mrst_a_x",  a_x, 0);
    check("mrst_b_hs", b_hs, 1);
    check("mrst_b_vs", b_vs, 1);
    check("mrst_b_de", b_de, 0);
    step(1);
    check("mrst2_a_de", a_de, 0);
    check("mrst2_a_fs", a_frame_start, 0);
    rst_n = 1'b1;
    step(1);
    check("mrel_fs", a_frame_start, 1);
    check("mrel_x",  a_x, 0);
    check("mrel_y",  a_y, 0);
    check("mrel_de", a_de, 1);
    step(2);
    check("mrel_b_de_x2", b_de, 0);
    step(1);
    check("mrel_b_de_x3", b_de, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
